// File: rtl/uart_report_encoder.sv
// uart_report_encoder: snapshots the active mode's value on a report
// trigger and streams it as an ASCII line into the UART TX FIFO.
module uart_report_encoder #(
    parameter int MAX_LEN = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_trigger,
    input  logic [1:0] i_mode,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [6:0] i_cent,
    input  logic [8:0] i_dist,
    input  logic [7:0] i_temp,
    input  logic [7:0] i_humi,
    input  logic       tx_full,
    output logic       push,
    output logic [7:0] tx_data,
    output logic       o_busy,
    output logic       o_drop
);

    localparam int IW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   last_idx;
    logic            busy_q;
    logic            drop_q;

    logic [1:0]      mode_q;
    logic [4:0]      hour_q;
    logic [5:0]      min_q;
    logic [5:0]      sec_q;
    logic [6:0]      cent_q;
    logic [8:0]      dist_q;
    logic [7:0]      temp_q;
    logic [7:0]      humi_q;

    logic [7:0][3:0] dig_d;
    logic [7:0][3:0] dig_q;

    // Two decimal digits {tens, ones}, clamped at 99.
    function automatic logic [7:0] two_dig(input logic [7:0] v);
        logic [7:0] s;
        s = (v > 8'd99) ? 8'd99 : v;
        return {4'(s / 8'd10), 4'(s % 8'd10)};
    endfunction

    function automatic logic [7:0] asc(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // Decimal digits of the snapshot, ordered as they appear in the line.
    always_comb begin
        dig_d = '0;
        unique case (mode_q)
            2'd0, 2'd1: begin
                {dig_d[0], dig_d[1]} = two_dig(8'(hour_q));
                {dig_d[2], dig_d[3]} = two_dig(8'(min_q));
                {dig_d[4], dig_d[5]} = two_dig(8'(sec_q));
                {dig_d[6], dig_d[7]} = two_dig(8'(cent_q));
            end
            2'd2: begin
                dig_d[0] = 4'(dist_q / 9'd100);
                dig_d[1] = 4'((dist_q / 9'd10) % 9'd10);
                dig_d[2] = 4'(dist_q % 9'd10);
            end
            2'd3: begin
                {dig_d[0], dig_d[1]} = two_dig(temp_q);
                {dig_d[2], dig_d[3]} = two_dig(humi_q);
            end
        endcase
    end

    // Index of the final LF for the latched mode.
    always_comb begin
        last_idx = IW'(14);
        unique case (mode_q)
            2'd0, 2'd1: last_idx = IW'(14);
            2'd2:       last_idx = IW'(9);
            2'd3:       last_idx = IW'(10);
        endcase
    end

    assign push = (state_q == S_SEND) & ~tx_full;

    // Byte selection from the registered digits; zero outside SEND.
    always_comb begin
        tx_data = 8'h00;
        if (state_q == S_SEND) begin
            unique case (mode_q)
                2'd0, 2'd1: begin
                    case (idx_q)
                        IW'(0):  tx_data = mode_q[0] ? "W" : "S";
                        IW'(1):  tx_data = " ";
                        IW'(2):  tx_data = asc(dig_q[0]);
                        IW'(3):  tx_data = asc(dig_q[1]);
                        IW'(4):  tx_data = ":";
                        IW'(5):  tx_data = asc(dig_q[2]);
                        IW'(6):  tx_data = asc(dig_q[3]);
                        IW'(7):  tx_data = ":";
                        IW'(8):  tx_data = asc(dig_q[4]);
                        IW'(9):  tx_data = asc(dig_q[5]);
                        IW'(10): tx_data = ".";
                        IW'(11): tx_data = asc(dig_q[6]);
                        IW'(12): tx_data = asc(dig_q[7]);
                        IW'(13): tx_data = 8'h0D;
                        IW'(14): tx_data = 8'h0A;
                        default: tx_data = 8'h00;
                    endcase
                end
                2'd2: begin
                    case (idx_q)
                        IW'(0):  tx_data = "D";
                        IW'(1):  tx_data = " ";
                        IW'(2):  tx_data = asc(dig_q[0]);
                        IW'(3):  tx_data = asc(dig_q[1]);
                        IW'(4):  tx_data = asc(dig_q[2]);
                        IW'(5):  tx_data = " ";
                        IW'(6):  tx_data = "c";
                        IW'(7):  tx_data = "m";
                        IW'(8):  tx_data = 8'h0D;
                        IW'(9):  tx_data = 8'h0A;
                        default: tx_data = 8'h00;
                    endcase
                end
                2'd3: begin
                    case (idx_q)
                        IW'(0):  tx_data = "T";
                        IW'(1):  tx_data = " ";
                        IW'(2):  tx_data = asc(dig_q[0]);
                        IW'(3):  tx_data = asc(dig_q[1]);
                        IW'(4):  tx_data = " ";
                        IW'(5):  tx_data = "H";
                        IW'(6):  tx_data = " ";
                        IW'(7):  tx_data = asc(dig_q[2]);
                        IW'(8):  tx_data = asc(dig_q[3]);
                        IW'(9):  tx_data = 8'h0D;
                        IW'(10): tx_data = 8'h0A;
                        default: tx_data = 8'h00;
                    endcase
                end
            endcase
        end
    end

    // Control FSM: snapshot on trigger, load digits, stream bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            mode_q  <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            cent_q  <= '0;
            dist_q  <= '0;
            temp_q  <= '0;
            humi_q  <= '0;
            dig_q   <= '0;
        end else begin
            drop_q <= i_trigger && (state_q != S_IDLE);
            unique case (state_q)
                S_IDLE: begin
                    if (i_trigger) begin
                        mode_q  <= i_mode;
                        hour_q  <= i_hour;
                        min_q   <= i_min;
                        sec_q   <= i_sec;
                        cent_q  <= i_cent;
                        dist_q  <= i_dist;
                        temp_q  <= i_temp;
                        humi_q  <= i_humi;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    dig_q   <= dig_d;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (push) begin
                        if (idx_q == last_idx) begin
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_busy = busy_q;
    assign o_drop = drop_q;

endmodule

// File: tb/tb_uart_report_encoder.sv
// tb_uart_report_encoder: directed lines with hand-written expected text;
// expected bytes are queued at trigger time and popped by a push monitor.
`timescale 1ns/1ps
module tb_uart_report_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_trigger = 1'b0;
    logic [1:0] i_mode = '0;
    logic [4:0] i_hour = '0;
    logic [5:0] i_min = '0;
    logic [5:0] i_sec = '0;
    logic [6:0] i_cent = '0;
    logic [8:0] i_dist = '0;
    logic [7:0] i_temp = '0;
    logic [7:0] i_humi = '0;
    logic       tx_full = 1'b0;
    logic       push;
    logic [7:0] tx_data;
    logic       o_busy;
    logic       o_drop;

    logic [7:0] sb[$];
    logic [7:0] mon_exp;
    int         checks = 0;
    int         errors = 0;
    int         pushes = 0;
    int         p0;

    uart_report_encoder #(.MAX_LEN(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_trigger (i_trigger),
        .i_mode    (i_mode),
        .i_hour    (i_hour),
        .i_min     (i_min),
        .i_sec     (i_sec),
        .i_cent    (i_cent),
        .i_dist    (i_dist),
        .i_temp    (i_temp),
        .i_humi    (i_humi),
        .tx_full   (tx_full),
        .push      (push),
        .tx_data   (tx_data),
        .o_busy    (o_busy),
        .o_drop    (o_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && push) begin
            pushes++;
            chk("push_while_full", {31'd0, tx_full}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_push actual=%0h required=none",
                         tx_data);
            end else begin
                mon_exp = sb.pop_front();
                chk("tx_byte", {24'd0, tx_data}, {24'd0, mon_exp});
            end
        end
    end

    task automatic push_line(input string s);
        for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
    endtask

    // Called #1 after a rising edge; returns #1 after the sampling edge.
    task automatic fire(input logic [1:0] m, input logic [4:0] hr,
                        input logic [5:0] mi, input logic [5:0] se,
                        input logic [6:0] ce, input logic [8:0] di,
                        input logic [7:0] te, input logic [7:0] hu);
        i_mode = m; i_hour = hr; i_min = mi; i_sec = se;
        i_cent = ce; i_dist = di; i_temp = te; i_humi = hu;
        p0 = pushes;
        i_trigger = 1'b1;
        @(posedge clk);
        #1 i_trigger = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int len);
        int n = 0;
        while ((o_busy || sb.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_timeout"}, {31'd0, n >= 300}, 32'd0);
        chk({name, "_left"}, sb.size(), 32'd0);
        chk({name, "_len"}, pushes - p0, len);
        chk({name, "_busy"}, {31'd0, o_busy}, 32'd0);
        sb.delete();
    endtask

    // Returns #1 after the edge that consumed the k-th byte.
    task automatic wait_pushes(input int k);
        int n = 0;
        int c = 0;
        while (c < k && n < 300) begin
            @(negedge clk);
            if (push) c++;
            n++;
        end
        chk("wait_pushes", c, k);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("idle_push", {31'd0, push}, 32'd0);
            chk("idle_busy", {31'd0, o_busy}, 32'd0);
            chk("idle_data", {24'd0, tx_data}, 32'd0);
        end

        push_line("W 09:05:42.07");
        fire(2'd1, 5'd9, 6'd5, 6'd42, 7'd7, 9'd0, 8'd0, 8'd0);
        chk("lat_load_push", {31'd0, push}, 32'd0);
        chk("lat_busy", {31'd0, o_busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("lat_first_push", {31'd0, push}, 32'd1);
        chk("lat_first_byte", {24'd0, tx_data}, 32'h57);
        wait_idle("line_w", 15);

        push_line("D 007 cm");
        fire(2'd2, 5'd0, 6'd0, 6'd0, 7'd0, 9'd7, 8'd0, 8'd0);
        wait_idle("line_d7", 10);
        push_line("T 25 H 99");
        fire(2'd3, 5'd0, 6'd0, 6'd0, 7'd0, 9'd0, 8'd25, 8'd120);
        wait_idle("line_t", 11);
        push_line("D 511 cm");
        fire(2'd2, 5'd3, 6'd3, 6'd3, 7'd3, 9'd511, 8'd200, 8'd200);
        wait_idle("line_d511", 10);

        push_line("S 23:59:59.99");
        fire(2'd0, 5'd23, 6'd59, 6'd59, 7'd99, 9'd0, 8'd0, 8'd0);
        wait_pushes(3);
        tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_push", {31'd0, push}, 32'd0);
            chk("stall_busy", {31'd0, o_busy}, 32'd1);
        end
        @(posedge clk);
        #1 tx_full = 1'b0;
        wait_idle("line_stall", 15);

        push_line("S 12:34:56.78");
        fire(2'd0, 5'd12, 6'd34, 6'd56, 7'd78, 9'd0, 8'd0, 8'd0);
        wait_pushes(2);
        i_min = 6'd11;
        i_mode = 2'd2;
        i_trigger = 1'b1;
        @(posedge clk);
        #1 i_trigger = 1'b0;
        chk("drop_pulse", {31'd0, o_drop}, 32'd1);
        @(posedge clk);
        #1;
        chk("drop_clear", {31'd0, o_drop}, 32'd0);
        wait_idle("line_drop", 15);

        push_line("S 01:02:03.04");
        fire(2'd0, 5'd1, 6'd2, 6'd3, 7'd4, 9'd0, 8'd0, 8'd0);
        wait_pushes(6);
        rst = 1'b0;
        #1;
        chk("rst_push", {31'd0, push}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_push", {31'd0, push}, 32'd0);
            chk("post_rst_busy", {31'd0, o_busy}, 32'd0);
        end
        push_line("W 10:20:30.40");
        fire(2'd1, 5'd10, 6'd20, 6'd30, 7'd40, 9'd0, 8'd0, 8'd0);
        wait_idle("line_post_rst", 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
